sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
Per-scanline sprite engine controller. It holds a 16-entry sprite attribute table and, on each horizontal blank, scans the table for sprites that intersect the next scanline. It selects up to SLOTS of them in ascending index order and fetches each selected sprite's 8-pixel row from shared pattern memory over a req/ack port. During active display it composes the loaded slots into one priority-resolved pixel stream for the video mixer.

Parameters:
NUM_SPRITES, 16, attribute table entries (index width 4)
SLOTS, 4, max sprites rendered per scanline

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hpos  in  8  current horizontal pixel position
vpos  in  7  current scanline
hblank  in  1  high during horizontal blank
vsync  in  1  vertical sync
cpu_we  in  1  attribute table write strobe
cpu_addr  in  6  {sprite[3:0], field[1:0]}; field 0=X, 1=Y, 2=pattern, 3=flags
cpu_data  in  8  attribute write data
pat_req  out  1  pattern fetch request
pat_addr  out  8  {pattern[4:0], row[2:0]}
pat_ack  in  1  fetch acknowledge; pat_data valid in the same cycle
pat_data  in  8  pattern row byte
pixel  out  1  composed sprite pixel (registered)
sprite_id  out  4  index of the winning sprite; 0 when pixel=0
overflow  out  1  sticky: more than SLOTS sprites on some line this frame

Behaviour:
- Reset, asynchronous:
  - attribute table cleared to 0 (all sprites disabled)
  - all slots invalid; FSM in IDLE
  - pixel=0, sprite_id=0, pat_req=0, pat_addr=0, overflow=0
- Attribute fields:
  - X: 8-bit
  - Y: bits[6:0] used, bit7 ignored
  - pattern: bits[4:0] used
  - flags: bit0=enable, bit1=hflip; other bits stored but ignored
- CPU writes take effect at the next clk edge and are accepted in any state. A same-cycle scan read of the entry being written returns the old value.
- Target line is tv = vpos+1 (7-bit wrap: 127 -> 0), sampled at hblank rising edge.
- Visibility: sprite is visible when enable=1 and (tv - Y[6:0]) mod 128 < 8. row = (tv - Y)[2:0].
- FSM:
  - IDLE -> SCAN on hblank rising edge (registered edge detect). Entry actions: all slots invalidated, sprite counter=0, slot counter=0.
  - SCAN: examines one sprite per clock, index 0..15.
    - Visible and slot counter < SLOTS: record {index, X, hflip, pattern, row} in the next slot; slot counter increments.
    - Visible and slot counter = SLOTS: set overflow; sprite skipped.
    - After index 15 -> FETCH, or -> IDLE if no slots were recorded.
  - FETCH: for each recorded slot in order:
    - Assert pat_req with pat_addr={pattern,row}; hold both stable until pat_ack=1.
    - In the ack cycle, latch pat_data into the slot's row register and mark the slot valid.
    - pat_req deasserts in the following cycle.
    - Next slot's request starts no earlier than the cycle after that.
    - After the last slot -> IDLE.
- Abort: hblank falling edge while not IDLE -> IDLE immediately, pat_req dropped.
  - Slots already fetched remain valid; the rest stay invalid.
  - An ack arriving in the same cycle as the falling edge is still latched.
- vsync rising edge: clears overflow and invalidates all slots; FSM forced to IDLE.
  - Takes precedence over a simultaneous hblank rising edge; no scan starts that cycle.
- Rendering, per slot:
  - dx = (hpos - X) mod 256; slot hit when valid and dx < 8.
  - Bit index b = dx[2:0], or 7-dx[2:0] when hflip; bit0 is leftmost without flip.
  - Slot pixel = row_reg[b].
- Priority: lowest slot number with slot pixel=1 wins; this is also the lowest sprite index.
- Output timing: pixel/sprite_id registered, one clk of latency from hpos. Forced 0 when hblank=1 in the sampling cycle.
- Minimum hblank for a full load: 1 + NUM_SPRITES + SLOTS*(2+ack latency) clocks. Shorter hblank yields partial slots, with no error flag.

Decomposition:
- Package sprite_pkg:
  - field offsets X/Y/PAT/FLAGS
  - flag bit positions ENABLE, HFLIP
  - FSM state enum IDLE/SCAN/FETCH
  - slot record typedef {valid, index[3:0], x[7:0], hflip, pattern[4:0], row[2:0], bits[7:0]}
- One sub-module, sprite_slot_render: takes hpos and one slot record; outputs hit bit. Instantiated SLOTS times in the top module.

Test Plan:
- Sprite 3: X=10, Y=20, pattern 5, enable; pattern row 2 = 0x01; vpos=21, hblank pulse, ack after 2 cycles -> pat_addr=0x2A; during the line, pixel=1 only for hpos=10, sprite_id=3, one cycle later.
- Same setup with hflip=1 -> pixel=1 only for hpos=17.
- Sprites 0..5 all enabled, Y=0, at X=0,10,20,30,40,50; vpos=127 (tv=0) -> exactly 4 fetches, for sprites 0-3; sprites 4,5 never shown; overflow=1 until the next vsync rising edge, then 0.
- Sprites 1 and 2 overlap at X=50, both rows 0xFF -> sprite_id=1 across hpos 50..57.
- 4 visible sprites, ack latency 10, hblank falls after the 2nd ack -> pat_req=0 next cycle; only 2 sprites render.
- Reset asserted mid-FETCH with pat_req=1 -> pat_req, pixel, overflow all 0 immediately; table cleared, so nothing renders on the following line.

Source files
------------

// File: rtl/sprite_line_scheduler_pkg.sv
// sprite_pkg: shared constants, FSM states and slot record for the sprite line scheduler
package sprite_pkg;
   localparam int NUM_SPRITES = 16;
   localparam int SLOTS = 4;
   localparam logic [1:0] FLD_X = 2'd0;
   localparam logic [1:0] FLD_Y = 2'd1;
   localparam logic [1:0] FLD_PAT = 2'd2;
   localparam logic [1:0] FLD_FLAGS = 2'd3;
   localparam int ENABLE = 0;
   localparam int HFLIP = 1;
   typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_t;
   typedef struct packed {
      logic       valid;
      logic [3:0] index;
      logic [7:0] x;
      logic       hflip;
      logic [4:0] pattern;
      logic [2:0] row;
      logic [7:0] bits;
   } slot_t;
endpackage

// File: rtl/sprite_line_scheduler_slot_render.sv
// sprite_slot_render: decides whether one loaded slot paints an opaque pixel at hpos
module sprite_slot_render
   import sprite_pkg::*;
(
   input  logic [7:0] hpos,
   input  slot_t      slot,
   output logic       hit
);
   logic [7:0] dx;
   logic [2:0] b;
   // horizontal offset into the sprite, mirrored when flipped, selects one row bit
   always_comb begin
      dx = hpos - slot.x;
      b = slot.hflip ? ~dx[2:0] : dx[2:0];
      hit = slot.valid && dx[7:3] == 5'd0 && slot.bits[b];
   end
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite selection, pattern fetch and pixel composition
module sprite_line_scheduler
   import sprite_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] hpos,
   input  logic [6:0] vpos,
   input  logic       hblank,
   input  logic       vsync,
   input  logic       cpu_we,
   input  logic [5:0] cpu_addr,
   input  logic [7:0] cpu_data,
   output logic       pat_req,
   output logic [7:0] pat_addr,
   input  logic       pat_ack,
   input  logic [7:0] pat_data,
   output logic       pixel,
   output logic [3:0] sprite_id,
   output logic       overflow
);
   logic [7:0] tbl [NUM_SPRITES][4];
   slot_t      slots [SLOTS];
   state_t     state;
   logic [3:0] spr_cnt;
   logic [2:0] slot_cnt;
   logic [2:0] fet;
   logic [6:0] tv;
   logic       hblank_q;
   logic       vsync_q;
   logic       hb_rise;
   logic       hb_fall;
   logic       vs_rise;
   logic [7:0] cx;
   logic [7:0] cy;
   logic [7:0] cp;
   logic [7:0] cf;
   logic [6:0] dy;
   logic       vis;
   logic       rec;
   logic [SLOTS-1:0] hits;
   logic       win;
   logic [3:0] win_id;

   // edge detects and the scan-side view of the entry under examination
   always_comb begin
      hb_rise = hblank && !hblank_q;
      hb_fall = !hblank && hblank_q;
      vs_rise = vsync && !vsync_q;
      cx = tbl[spr_cnt][FLD_X];
      cy = tbl[spr_cnt][FLD_Y];
      cp = tbl[spr_cnt][FLD_PAT];
      cf = tbl[spr_cnt][FLD_FLAGS];
      dy = tv - cy[6:0];
      vis = cf[ENABLE] && dy[6:3] == 4'd0;
      rec = vis && slot_cnt < 3'(SLOTS);
   end

   // attribute table, writable from the CPU at any time
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++)
            for (int j = 0; j < 4; j++)
               tbl[i][j] <= 8'h00;
      end else if (cpu_we) begin
         tbl[cpu_addr[5:2]][cpu_addr[1:0]] <= cpu_data;
      end

   // scan/fetch sequencer with abort on hblank fall and frame restart on vsync
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         spr_cnt <= 4'd0;
         slot_cnt <= 3'd0;
         fet <= 3'd0;
         tv <= 7'd0;
         pat_req <= 1'b0;
         pat_addr <= 8'h00;
         overflow <= 1'b0;
         hblank_q <= 1'b0;
         vsync_q <= 1'b0;
         for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      end else begin
         hblank_q <= hblank;
         vsync_q <= vsync;
         if (vs_rise) begin
            overflow <= 1'b0;
            state <= IDLE;
            pat_req <= 1'b0;
            for (int i = 0; i < SLOTS; i++) slots[i].valid <= 1'b0;
         end else begin
            if (state == FETCH && pat_req && pat_ack) begin
               slots[fet[1:0]].bits <= pat_data;
               slots[fet[1:0]].valid <= 1'b1;
               pat_req <= 1'b0;
               fet <= fet + 3'd1;
            end
            if (hb_fall && state != IDLE) begin
               state <= IDLE;
               pat_req <= 1'b0;
            end else if (state == IDLE) begin
               if (hb_rise) begin
                  state <= SCAN;
                  tv <= vpos + 7'd1;
                  spr_cnt <= 4'd0;
                  slot_cnt <= 3'd0;
                  fet <= 3'd0;
                  for (int i = 0; i < SLOTS; i++) slots[i].valid <= 1'b0;
               end
            end else if (state == SCAN) begin
               if (rec) begin
                  slots[slot_cnt[1:0]] <= {1'b0, spr_cnt, cx, cf[HFLIP], cp[4:0], dy[2:0], 8'h00};
                  slot_cnt <= slot_cnt + 3'd1;
               end else if (vis) begin
                  overflow <= 1'b1;
               end
               spr_cnt <= spr_cnt + 4'd1;
               if (spr_cnt == 4'(NUM_SPRITES - 1))
                  state <= (slot_cnt != 3'd0 || rec) ? FETCH : IDLE;
            end else if (!pat_req) begin
               if (fet == slot_cnt) begin
                  state <= IDLE;
               end else begin
                  pat_req <= 1'b1;
                  pat_addr <= {slots[fet[1:0]].pattern, slots[fet[1:0]].row};
               end
            end
         end
      end

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      sprite_slot_render u_render (.hpos(hpos), .slot(slots[g]), .hit(hits[g]));
   end

   // lowest-numbered opaque slot wins, which is also the lowest sprite index
   always_comb begin
      win = 1'b0;
      win_id = 4'd0;
      for (int i = SLOTS - 1; i >= 0; i--)
         if (hits[i]) begin
            win = 1'b1;
            win_id = slots[i].index;
         end
   end

   // registered pixel output, blanked during hblank
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pixel <= 1'b0;
         sprite_id <= 4'd0;
      end else begin
         pixel <= win && !hblank;
         sprite_id <= (win && !hblank) ? win_id : 4'd0;
      end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed checks of sprite selection, fetch and rendering
module tb_sprite_line_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] hpos = 8'd0;
   logic [6:0] vpos = 7'd0;
   logic       hblank = 1'b0;
   logic       vsync = 1'b0;
   logic       cpu_we = 1'b0;
   logic [5:0] cpu_addr = 6'd0;
   logic [7:0] cpu_data = 8'd0;
   logic       pat_req;
   logic [7:0] pat_addr;
   logic       pat_ack = 1'b0;
   logic [7:0] pat_data = 8'd0;
   logic       pixel;
   logic [3:0] sprite_id;
   logic       overflow;

   int total = 0;
   int bad = 0;
   int lat = 2;
   int nf = 0;
   int cnt = 0;
   logic [7:0] pmem [256];
   logic [7:0] flog [16];
   logic       pix [256];
   logic [3:0] ids [256];

   sprite_line_scheduler dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hblank(hblank), .vsync(vsync),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .pat_req(pat_req), .pat_addr(pat_addr), .pat_ack(pat_ack), .pat_data(pat_data),
      .pixel(pixel), .sprite_id(sprite_id), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // pattern memory responder: acks after lat cycles of request, logs each fetched address
   initial forever begin
      @(negedge clk);
      if (pat_ack) begin
         pat_ack = 1'b0;
         cnt = 0;
      end else if (pat_req) begin
         cnt++;
         if (cnt >= lat) begin
            pat_ack = 1'b1;
            pat_data = pmem[pat_addr];
            if (nf < 16) flog[nf] = pat_addr;
            nf++;
         end
      end else begin
         cnt = 0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic wr(input int s, input int f, input int d);
      @(negedge clk);
      cpu_we = 1'b1;
      cpu_addr = {4'(s), 2'(f)};
      cpu_data = 8'(d);
      @(negedge clk);
      cpu_we = 1'b0;
   endtask

   task automatic spr(input int s, input int x, input int y, input int p, input int fl);
      wr(s, 0, x);
      wr(s, 1, y);
      wr(s, 2, p);
      wr(s, 3, fl);
   endtask

   task automatic sweep(output int ones);
      ones = 0;
      for (int h = 0; h <= 256; h++) begin
         @(negedge clk);
         if (h > 0) begin
            pix[h-1] = pixel;
            ids[h-1] = sprite_id;
            ones += int'(pixel);
         end
         if (h < 256) hpos = 8'(h);
      end
   endtask

   task automatic line(input int v, input int n, output int ones);
      @(negedge clk);
      vpos = 7'(v);
      hblank = 1'b1;
      repeat (n) @(negedge clk);
      hblank = 1'b0;
      sweep(ones);
   endtask

   initial begin
      int ones;
      int base;
      int w;
      for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_pixel", 32'(pixel), 0);
      chk("rst_id", 32'(sprite_id), 0);
      chk("rst_req", 32'(pat_req), 0);
      chk("rst_addr", 32'(pat_addr), 0);
      chk("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;

      // single sprite, no flip
      spr(3, 10, 20, 5, 1);
      pmem[8'h2A] = 8'h01;
      line(21, 60, ones);
      chk("t1_nf", 32'(nf), 1);
      chk("t1_addr", 32'(flog[0]), 32'h2A);
      chk("t1_ones", 32'(ones), 1);
      chk("t1_pix10", 32'(pix[10]), 1);
      chk("t1_id10", 32'(ids[10]), 3);
      @(negedge clk);
      hpos = 8'd10;
      #1;
      chk("t1_lat_pre", 32'(pixel), 0);
      @(posedge clk);
      #1;
      chk("t1_lat_post", 32'(pixel), 1);
      chk("t1_lat_id", 32'(sprite_id), 3);

      // same sprite, horizontally flipped
      wr(3, 3, 3);
      line(21, 60, ones);
      chk("t2_nf", 32'(nf), 2);
      chk("t2_ones", 32'(ones), 1);
      chk("t2_pix17", 32'(pix[17]), 1);

      // six sprites on one line: only the first four load, overflow sticks
      for (int i = 0; i < 6; i++) begin
         spr(i, 10 * i, 0, i, 1);
         pmem[i*8] = 8'h01;
      end
      line(127, 60, ones);
      chk("t3_nf", 32'(nf), 6);
      for (int i = 0; i < 4; i++) chk("t3_addr", 32'(flog[2+i]), 32'(i * 8));
      chk("t3_ones", 32'(ones), 4);
      chk("t3_pix30", 32'(pix[30]), 1);
      chk("t3_pix40", 32'(pix[40]), 0);
      chk("t3_pix50", 32'(pix[50]), 0);
      chk("t3_id20", 32'(ids[20]), 2);
      chk("t3_ovf", 32'(overflow), 1);
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      chk("t3_ovf_vs", 32'(overflow), 0);
      vsync = 1'b0;
      hpos = 8'd0;
      @(negedge clk);
      chk("t3_vs_inval", 32'(pixel), 0);

      // overlapping sprites 1 and 2: lower index wins
      wr(0, 3, 0);
      wr(3, 3, 0);
      wr(4, 3, 0);
      wr(5, 3, 0);
      wr(1, 0, 50);
      wr(2, 0, 50);
      pmem[8] = 8'hFF;
      pmem[16] = 8'hFF;
      line(127, 60, ones);
      chk("t4_nf", 32'(nf), 8);
      chk("t4_ones", 32'(ones), 8);
      chk("t4_id50", 32'(ids[50]), 1);
      chk("t4_id57", 32'(ids[57]), 1);
      chk("t4_pix49", 32'(pix[49]), 0);
      chk("t4_pix58", 32'(pix[58]), 0);

      // slow acks, hblank ends after the second fetch
      for (int i = 0; i < 4; i++) begin
         spr(i, 10 * i, 0, i, 1);
         pmem[i*8] = 8'h01;
      end
      lat = 10;
      base = nf;
      @(negedge clk);
      vpos = 7'd127;
      hblank = 1'b1;
      w = 0;
      while (nf < base + 2 && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("t5_wait", 32'(nf == base + 2), 1);
      repeat (3) @(negedge clk);
      chk("t5_req_on", 32'(pat_req), 1);
      hblank = 1'b0;
      @(negedge clk);
      chk("t5_req_off", 32'(pat_req), 0);
      sweep(ones);
      chk("t5_nf", 32'(nf), 32'(base + 2));
      chk("t5_ones", 32'(ones), 2);
      chk("t5_pix10", 32'(pix[10]), 1);
      chk("t5_pix20", 32'(pix[20]), 0);

      // reset in the middle of a fetch
      spr(4, 40, 0, 4, 1);
      base = nf;
      @(negedge clk);
      vpos = 7'd127;
      hblank = 1'b1;
      w = 0;
      while (!pat_req && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("t6_wait", 32'(pat_req), 1);
      chk("t6_ovf_pre", 32'(overflow), 1);
      reset = 1'b1;
      #1;
      chk("t6_req", 32'(pat_req), 0);
      chk("t6_ovf", 32'(overflow), 0);
      chk("t6_pixel", 32'(pixel), 0);
      chk("t6_addr", 32'(pat_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      hblank = 1'b0;
      line(127, 60, ones);
      chk("t6_nf", 32'(nf), 32'(base));
      chk("t6_ones", 32'(ones), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
